// File: rtl/mem_access_ctrl_pkg.sv
// Shared memory-operation definitions for the access controller and its
// requesters. State encodings live inside the controller, not here.
package mem_access_ctrl_pkg;

    // Access size codes shared with the requester and the memory.
    localparam logic [1:0] MEMOP_BYTE     = 2'b00;
    localparam logic [1:0] MEMOP_HALFWORD = 2'b01;
    localparam logic [1:0] MEMOP_WORD     = 2'b10;

    // Number of bytes in an access, minus one. The unused code 2'b11
    // behaves as a full word.
    function automatic logic [1:0] memop_size_m1(input logic [1:0] op);
        case (op)
            MEMOP_BYTE:     memop_size_m1 = 2'd0;
            MEMOP_HALFWORD: memop_size_m1 = 2'd1;
            default:        memop_size_m1 = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Byte-lane steering for one memory word of an unaligned access.
// Request byte j lives at byte address addr + j. For word 0 that is lane
// (off + j); for word 1 it is lane (off + j - 4). Lanes outside the access
// keep the word's original contents on the write side and contribute zero
// on the read side, so the two instances' extract outputs can be ORed.
module byte_lane_merge (
    input  logic        word_sel,   // 0 = first word, 1 = second word
    input  logic [1:0]  off,        // byte offset of the access in word 0
    input  logic [1:0]  size_m1,    // access size in bytes, minus one
    input  logic [31:0] rword,      // word as read from memory
    input  logic [31:0] wdata,      // right-justified store data
    output logic [31:0] merged,     // rword with the target lanes replaced
    output logic [31:0] extract     // target lanes, right-justified
);

    // Map every lane of this word to its request byte, if it has one.
    always_comb begin
        int j;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; a path that skips one infers a latch.
        merged  = rword;
        extract = '0;
        for (int k = 0; k < 4; k++) begin
            j = k + (word_sel ? 4 : 0) - int'(off);
            if (j >= 0 && j <= int'(size_m1)) begin
                merged[k*8 +: 8]  = wdata[j*8 +: 8];
                extract[j*8 +: 8] = rword[k*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte/halfword/word access controller in front of a word-wide memory.
// Unaligned and sub-word accesses are split into at most two word
// accesses; partial stores use read-modify-write so untouched bytes are
// preserved. Out-of-range accesses respond with an error and never touch
// memory.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int MEMSIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_op,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_memop,
    output logic        mem_sext,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        WR0,
        RD1,
        WR1,
        RESP
    } state_t;

    state_t state, state_next;

    // Request fields captured at acceptance.
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        sext_q;
    logic        err_q;

    // Memory words captured in RD0 / RD1.
    logic [31:0] word0_q;
    logic [31:0] word1_q;

    logic        accept;
    logic [1:0]  req_op_norm;
    logic [1:0]  req_size_m1;
    logic [32:0] req_last_byte;
    logic        req_err;
    logic        req_full_word_store;

    logic [1:0]  size_m1_q;
    logic        crossing;
    logic [31:0] word0_addr;
    logic [31:0] merged0, merged1;
    logic [31:0] extract0, extract1;
    logic [31:0] extract_all;
    logic [31:0] load_result;

    // Decode of the incoming request, used only at the acceptance edge.
    assign accept              = req_valid && req_ready;
    assign req_op_norm         = (req_op == 2'b11) ? MEMOP_WORD : req_op;
    assign req_size_m1         = memop_size_m1(req_op_norm);
    // 33 bits so an address near 2^32 cannot wrap back into range.
    assign req_last_byte       = {1'b0, req_addr} + {31'd0, req_size_m1};
    assign req_err             = req_last_byte >= 33'(MEMSIZE);
    assign req_full_word_store = req_write && (req_op_norm == MEMOP_WORD)
                                 && (req_addr[1:0] == 2'b00);

    // Decode of the registered access.
    assign size_m1_q  = memop_size_m1(op_q);
    assign crossing   = ({1'b0, addr_q[1:0]} + {1'b0, size_m1_q}) > 3'd3;
    assign word0_addr = {addr_q[31:2], 2'b00};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture request fields at acceptance and memory words as RD0/RD1 exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= MEMOP_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            word0_q <= '0;
            word1_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= req_op_norm;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
                sext_q  <= req_sext;
                err_q   <= req_err;
            end
            if (state == RD0) begin
                word0_q <= mem_rdata;
            end
            if (state == RD1) begin
                word1_q <= mem_rdata;
            end
        end
    end

    // Next-state sequencing for loads, RMW stores and error responses.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (req_full_word_store) begin
                        state_next = WR0;
                    end else begin
                        state_next = RD0;
                    end
                end
            end
            RD0: begin
                if (write_q) begin
                    state_next = WR0;
                end else if (crossing) begin
                    state_next = RD1;
                end else begin
                    state_next = RESP;
                end
            end
            WR0:     state_next = crossing ? RD1 : RESP;
            RD1:     state_next = write_q ? WR1 : RESP;
            WR1:     state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    byte_lane_merge u_lane0 (
        .word_sel (1'b0),
        .off      (addr_q[1:0]),
        .size_m1  (size_m1_q),
        .rword    (word0_q),
        .wdata    (wdata_q),
        .merged   (merged0),
        .extract  (extract0)
    );

    byte_lane_merge u_lane1 (
        .word_sel (1'b1),
        .off      (addr_q[1:0]),
        .size_m1  (size_m1_q),
        .rword    (word1_q),
        .wdata    (wdata_q),
        .merged   (merged1),
        .extract  (extract1)
    );

    assign extract_all = extract0 | extract1;

    // Zero- or sign-extend the assembled load data to 32 bits.
    always_comb begin
        case (size_m1_q)
            2'd0:    load_result = {{24{sext_q & extract_all[7]}}, extract_all[7:0]};
            2'd1:    load_result = {{16{sext_q & extract_all[15]}}, extract_all[15:0]};
            default: load_result = extract_all;
        endcase
    end

    // Outputs are decoded from state so reset clears them immediately.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !write_q) ? load_result : '0;

    assign mem_memop  = MEMOP_WORD;
    assign mem_sext   = 1'b0;
    assign mem_write  = (state == WR0) || (state == WR1);
    assign mem_addr   = ((state == RD1) || (state == WR1)) ? (word0_addr + 32'd4)
                                                           : word0_addr;
    assign mem_wdata  = (state == WR1) ? merged1 : merged0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a behavioural word memory, a scoreboard of
// expected responses, and one task per scenario.
module tb_mem_access_ctrl;

    localparam int MEMSIZE = 1024;
    localparam logic [1:0] OP_B = 2'b00;
    localparam logic [1:0] OP_H = 2'b01;
    localparam logic [1:0] OP_W = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_op;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [1:0]  mem_memop;
    logic        mem_sext;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:MEMSIZE/4-1];
    int          wr_count = 0;
    int          checks   = 0;
    int          errors   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        is_load;
        int          lat;
        int          writes;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEMSIZE(MEMSIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_op     (req_op),
        .req_sext   (req_sext),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_memop  (mem_memop),
        .mem_sext   (mem_sext),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural memory: combinational read, write at the rising edge.
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[9:2]] = mem_wdata;
            wr_count = wr_count + 1;
        end
    end

    // Every memory write must target a word-aligned address.
    always @(negedge clk) begin
        if (rst_n && mem_write) begin
            checks++;
            if (mem_addr[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL mem_addr_align: got %h required low bits 00", mem_addr);
            end
        end
    end

    task automatic push_exp(input logic [31:0] rdata, input logic err, input logic is_load,
                            input int lat, input int writes, input string name);
        exp_t e;
        e.rdata = rdata; e.err = err; e.is_load = is_load;
        e.lat = lat; e.writes = writes; e.name = name;
        sb.push_back(e);
    endtask

    // Entered at the first falling edge after acceptance; waits (bounded)
    // for resp_valid and compares against the oldest scoreboard entry.
    task automatic wait_resp(input int w_base);
        exp_t e;
        int cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got response with no expectation");
            return;
        end
        e = sb.pop_front();
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: resp_valid got %b required 1", e.name, resp_valid);
            return;
        end
        checks++;
        if (cyc != e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", e.name, cyc, e.lat);
        end
        checks++;
        if (resp_err !== e.err) begin
            errors++;
            $display("FAIL %s err: got %b required %b", e.name, resp_err, e.err);
        end
        if (e.is_load || e.err) begin
            checks++;
            if (resp_rdata !== e.rdata) begin
                errors++;
                $display("FAIL %s rdata: got %h required %h", e.name, resp_rdata, e.rdata);
            end
        end
        checks++;
        if (wr_count - w_base != e.writes) begin
            errors++;
            $display("FAIL %s writes: got %0d required %0d", e.name, wr_count - w_base, e.writes);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: req_ready got %b required 1", req_ready);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] op, input logic sext,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_write = wr;
        req_op    = op;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic access(input logic wr, input logic [1:0] op, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_writes, input string name);
        int w_base;
        wait_ready();
        w_base = wr_count;
        push_exp(exp_rdata, exp_err, !wr, exp_lat, exp_writes, name);
        drive_req(wr, op, sext, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(w_base);
    endtask

    task automatic check_word(input int idx, input logic [31:0] exp, input string name);
        checks++;
        if (mem[idx] !== exp) begin
            errors++;
            $display("FAIL %s: mem word %0d got %h required %h", name, idx, mem[idx], exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 && req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_x: got %b required known", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_resp: got valid %b err %b rdata %h required 0 0 0",
                     resp_valid, resp_err, resp_rdata);
        end
        checks++;
        if (mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_write: got %b required 0", mem_write);
        end
        checks++;
        if (mem_memop !== OP_W || mem_sext !== 1'b0) begin
            errors++;
            $display("FAIL mem_constants: got memop %b sext %b required 10 0", mem_memop, mem_sext);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_loads();
        access(1'b0, OP_W,  1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, "load_word_aligned");
        access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, "load_op11");
        access(1'b0, OP_B,  1'b1, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, "load_byte_sext");
        access(1'b0, OP_B,  1'b0, 32'h21, 32'h0, 32'h00000080, 1'b0, 2, 0, "load_byte_zext");
        access(1'b0, OP_H,  1'b1, 32'h20, 32'h0, 32'hFFFF8000, 1'b0, 2, 0, "load_half_sext");
    endtask

    task automatic test_stores();
        access(1'b1, OP_H, 1'b0, 32'h33, 32'h0000AABB, 32'h0, 1'b0, 5, 2, "store_half_cross");
        check_word(12, 32'hBB223344, "store_half_cross_w0");
        check_word(13, 32'h556677AA, "store_half_cross_w1");
        access(1'b0, OP_H, 1'b1, 32'h33, 32'h0, 32'hFFFFAABB, 1'b0, 3, 0, "load_half_cross");
        access(1'b0, OP_W, 1'b0, 32'h31, 32'h0, 32'hAABB2233, 1'b0, 3, 0, "load_word_cross");
        access(1'b1, OP_B, 1'b0, 32'h12, 32'h0000005A, 32'h0, 1'b0, 3, 1, "store_byte_partial");
        check_word(4, 32'hDE5ABEEF, "store_byte_partial_mem");
        access(1'b1, OP_W, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, "store_word_aligned");
        check_word(16, 32'hCAFEF00D, "store_word_aligned_mem");
    endtask

    task automatic test_range();
        access(1'b0, OP_W, 1'b0, 32'h3FE, 32'h0, 32'h0, 1'b1, 1, 0, "load_out_of_range");
        access(1'b1, OP_W, 1'b0, 32'h3FD, 32'h12345678, 32'h0, 1'b1, 1, 0, "store_out_of_range");
        check_word(255, 32'h9A000000, "store_out_of_range_mem");
        access(1'b0, OP_B, 1'b0, 32'h3FF, 32'h0, 32'h0000009A, 1'b0, 2, 0, "load_last_byte");
        access(1'b0, OP_W, 1'b0, 32'h3FC, 32'h0, 32'h9A000000, 1'b0, 2, 0, "load_last_word");
    endtask

    task automatic test_reset_mid_op();
        int w_base;
        int seen_resp = 0;
        wait_ready();
        drive_req(1'b1, OP_H, 1'b0, 32'h53, 32'h0000CC11);
        @(posedge clk);
        @(negedge clk);              // RD0
        req_valid = 1'b0;
        @(negedge clk);              // WR0 (rewrites byte 0x53 with its own value)
        @(negedge clk);              // RD1
        checks++;
        if (mem_addr !== 32'h54 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_rd1: got addr %h write %b required 00000054 0", mem_addr, mem_write);
        end
        w_base = wr_count;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got write %b valid %b rdata %h required 0 0 0",
                     mem_write, resp_valid, resp_rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready: got %b required 1", req_ready);
        end
        repeat (6) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen_resp++;
        end
        checks++;
        if (seen_resp != 0 || wr_count != w_base) begin
            errors++;
            $display("FAIL mid_reset_abandon: got resp %0d writes %0d required 0 0",
                     seen_resp, wr_count - w_base);
        end
        check_word(20, 32'h11223344, "mid_reset_mem_w0");
        check_word(21, 32'h55667788, "mid_reset_mem_w1");
    endtask

    task automatic test_back_to_back();
        int w_base;
        wait_ready();
        w_base = wr_count;
        push_exp(32'h0, 1'b0, 1'b0, 2, 1, "b2b_first");
        drive_req(1'b1, OP_W, 1'b0, 32'h60, 32'h01020304);
        @(posedge clk);
        @(negedge clk);
        // Second store presented immediately; it must wait for the first.
        push_exp(32'h0, 1'b0, 1'b0, 3, 1, "b2b_second");
        drive_req(1'b1, OP_B, 1'b0, 32'h64, 32'h00000077);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_ready: got %b required 0", req_ready);
        end
        wait_resp(w_base);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_after_resp: got %b required 1", req_ready);
        end
        w_base = wr_count;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(w_base);
        check_word(24, 32'h01020304, "b2b_first_mem");
        check_word(25, 32'hAAAAAA77, "b2b_second_mem");
    endtask

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_op    = OP_W;
        req_sext  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < MEMSIZE/4; i++) mem[i] = 32'd0;
        mem[4]   = 32'hDEADBEEF;
        mem[8]   = 32'h00008000;
        mem[12]  = 32'h11223344;
        mem[13]  = 32'h55667788;
        mem[20]  = 32'h11223344;
        mem[21]  = 32'h55667788;
        mem[25]  = 32'hAAAAAAAA;
        mem[255] = 32'h9A000000;

        test_reset();
        test_loads();
        test_stores();
        test_range();
        test_reset_mid_op();
        test_back_to_back();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
